pressure_mat_ctrl: RTL and testbench

Conditions the raw store-entrance pressure-mat sensor into the clean, held `pressure` level consumed by the door opener, and counts accepted entries. It synchronises and debounces the mat, then keeps `pressure` asserted for a hold window after the customer steps off. While the obstruction sensor reports someone in the doorway, the hold is extended. It sits directly upstream of the door opener; `pressure` is its only control input.

---
 rtl/pressure_mat_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pressure_mat_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pressure_mat_ctrl.sv
// -----------------------------------------------------------------------------
// pressure_mat_ctrl
//
// Turns the raw, bouncy store-entrance pressure-mat contact into the clean,
// held `pressure` level used by the door opener, and counts accepted entries.
//
// Processing chain:
//   mat_raw -> 2-flop synchroniser -> debounce filter (filt)
//           -> IDLE / ACTIVE / HOLD controller -> pressure, entry_pulse,
//              entry_count
//
// Once the filtered mat releases, `pressure` stays high for a hold window of
// HOLD_CYC cycles. While the doorway obstruction sensor is active during that
// window, the window restarts. Stepping back onto the mat inside the window
// counts as the same customer: no new pulse and no new count.
//
// Parameters:
//   DEBOUNCE_CYC  consecutive differing samples needed to accept a level
//                 change (>= 1)
//   HOLD_CYC      cycles `pressure` stays high after the mat releases (>= 1)
//   CNT_W         width of entry_count
//
// Ports:
//   clk          in   system clock, rising-edge active
//   rst          in   asynchronous, active-high reset
//   mat_raw      in   raw mat contact, asynchronous to clk
//   obstruct     in   doorway obstruction sensor, synchronous to clk
//   pressure     out  registered, conditioned pressure level
//   entry_pulse  out  registered one-cycle pulse per accepted new entry
//   entry_count  out  registered, saturating count of accepted entries
// -----------------------------------------------------------------------------
module pressure_mat_ctrl #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int HOLD_CYC     = 8,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mat_raw,
   input  logic             obstruct,
   output logic             pressure,
   output logic             entry_pulse,
   output logic [CNT_W-1:0] entry_count
);

   // Debounce counter only needs to reach DEBOUNCE_CYC-1 before it is
   // cleared; hold counter must be able to hold HOLD_CYC itself.
   localparam int DCNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int HCNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;

   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_CYC);
   localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   logic              s1;
   logic              s2;
   logic              filt;
   logic [DCNT_W-1:0] dcnt;
   logic [HCNT_W-1:0] hcnt;
   state_t            state;

   // --------------------------------------------------------------------------
   // Synchroniser: mat_raw is asynchronous, so it passes through two flops
   // before any logic looks at it.
   // --------------------------------------------------------------------------
   // NOTE: every register here is reset asynchronously on rst rising, so
   // pressure drops at once even when the clock is mid-cycle; all sequential
   // state is written with non-blocking assignments so the flops update
   // together regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= mat_raw;
         s2 <= s1;
      end
   end

   // --------------------------------------------------------------------------
   // Debounce filter: filt follows s2 only after DEBOUNCE_CYC consecutive
   // samples that differ from the current filt. Any sample that agrees with
   // filt restarts the count, so shorter glitches are discarded.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt <= 1'b0;
         dcnt <= '0;
      end else if (s2 == filt) begin
         dcnt <= '0;
      end else if (dcnt == DCNT_LAST) begin
         // This edge sees the DEBOUNCE_CYC-th differing sample.
         filt <= s2;
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + DCNT_W'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Entry controller. All outputs are registered in this block, so nothing
   // reaches the door opener combinationally from the sensors.
   //
   // HOLD priority: filt high (same customer re-stepping) beats obstruct,
   // and obstruct beats expiry of the window.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         pressure    <= 1'b0;
         entry_pulse <= 1'b0;
         entry_count <= '0;
         hcnt        <= '0;
      end else begin
         // NOTE: entry_pulse is defaulted low and overridden below when an
         // entry is accepted; with non-blocking assignments the later write
         // wins, which yields a pulse exactly one cycle wide.
         entry_pulse <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (filt) begin
                  state       <= ST_ACTIVE;
                  pressure    <= 1'b1;
                  entry_pulse <= 1'b1;
                  // Saturate rather than wrap; the pulse still fires.
                  if (entry_count != CNT_MAX) begin
                     entry_count <= entry_count + CNT_W'(1);
                  end
               end
            end

            ST_ACTIVE: begin
               if (!filt) begin
                  state <= ST_HOLD;
                  hcnt  <= HOLD_LOAD;
               end
            end

            ST_HOLD: begin
               if (filt) begin
                  state <= ST_ACTIVE;
               end else if (obstruct) begin
                  // Someone in the doorway: restart the full window.
                  hcnt <= HOLD_LOAD;
               end else if (hcnt == HCNT_ONE) begin
                  state    <= ST_IDLE;
                  pressure <= 1'b0;
               end else begin
                  hcnt <= hcnt - HCNT_W'(1);
               end
            end

            default: begin
               // Unreachable encoding: fall back to a safe, released state.
               state    <= ST_IDLE;
               pressure <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pressure_mat_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pressure_mat_ctrl (DEBOUNCE_CYC=4, HOLD_CYC=8, CNT_W=8).
//
// Stimulus tasks push the expected output events (pressure rise, pressure
// fall, entry pulse with its count) into a queue with the edge number on
// which each must happen. An independent monitor samples the outputs on the
// falling edge, turns every observed change into an event and compares it
// against the head of the queue. A few direct checks cover the reset values
// and the final saturated count.
// -----------------------------------------------------------------------------
module tb_pressure_mat_ctrl;

   localparam int D = 4;
   localparam int H = 8;
   localparam int W = 8;
   localparam int LAT_RISE = D + 2;        // E0 -> pressure rise
   localparam int LAT_FALL = D + 2 + H;    // F0 -> pressure fall

   logic         clk      = 1'b0;
   logic         rst      = 1'b0;
   logic         mat_raw  = 1'b0;
   logic         obstruct = 1'b0;
   logic         pressure;
   logic         entry_pulse;
   logic [W-1:0] entry_count;

   pressure_mat_ctrl #(
      .DEBOUNCE_CYC (D),
      .HOLD_CYC     (H),
      .CNT_W        (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mat_raw     (mat_raw),
      .obstruct    (obstruct),
      .pressure    (pressure),
      .entry_pulse (entry_pulse),
      .entry_count (entry_count)
   );

   always #5 clk = ~clk;

   typedef enum logic [1:0] {EV_RISE, EV_FALL, EV_PULSE} ev_kind_t;
   typedef struct {
      int       edge_no;
      ev_kind_t kind;
      int       cnt;
   } ev_t;

   ev_t  exp_q[$];
   int   errors    = 0;
   int   checks    = 0;
   int   edge_n    = 0;
   int   exp_count = 0;
   logic prev_p    = 1'b0;

   // Rising-edge counter; edge k is the k-th posedge of clk.
   always @(posedge clk) edge_n++;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic expect_ev(input int e, input ev_kind_t k, input int c);
      ev_t ev;
      ev.edge_no = e;
      ev.kind    = k;
      ev.cnt     = c;
      exp_q.push_back(ev);
   endtask

   task automatic observe(input ev_kind_t k, input int c);
      ev_t ev;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got %s at edge %0d cnt %0d, required no event",
                  k.name(), edge_n, c);
      end else begin
         ev = exp_q.pop_front();
         if (ev.kind != k || ev.edge_no != edge_n || (k == EV_PULSE && ev.cnt != c)) begin
            errors++;
            $display("FAIL event: got %s at edge %0d cnt %0d, required %s at edge %0d cnt %0d",
                     k.name(), edge_n, c, ev.kind.name(), ev.edge_no, ev.cnt);
         end
      end
   endtask

   // Monitor: runs continuously, independent of the stimulus.
   always @(negedge clk) begin
      if (pressure && !prev_p) observe(EV_RISE, 0);
      if (!pressure && prev_p) observe(EV_FALL, 0);
      if (entry_pulse)         observe(EV_PULSE, int'(entry_count));
      prev_p = pressure;
   end

   // Called at a falling edge; returns at the falling edge after edge n.
   task automatic wait_to(input int n);
      while (edge_n < n) @(negedge clk);
   endtask

   // One customer: mat high for hold_n samples starting at E0, then low.
   // Returns F0, the first edge that samples the mat low.
   task automatic step(input int hold_n, input bit expect_fall, output int f0);
      int e0;
      mat_raw   = 1'b1;
      e0        = edge_n + 1;
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      expect_ev(e0 + LAT_RISE, EV_RISE, 0);
      expect_ev(e0 + LAT_RISE, EV_PULSE, exp_count);
      wait_to(e0 + hold_n - 1);
      mat_raw = 1'b0;
      f0      = edge_n + 1;
      if (expect_fall) expect_ev(f0 + LAT_FALL, EV_FALL, 0);
   endtask

   initial begin
      int f0;
      int f1;

      // ---- Power-on reset ---------------------------------------------------
      #1 rst = 1'b1;
      #1;
      check("por_pressure", int'(pressure), 0);
      check("por_pulse",    int'(entry_pulse), 0);
      check("por_count",    int'(entry_count), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // ---- Clean step: 20 cycles on, then off -------------------------------
      step(20, 1'b1, f0);
      wait_to(f0 + LAT_FALL + 3);
      check("count_after_step", int'(entry_count), 1);

      // ---- Bounce: 3 high, 1 low, 2 high, low -------------------------------
      mat_raw = 1'b1;
      repeat (3) @(negedge clk);
      mat_raw = 1'b0;
      @(negedge clk);
      mat_raw = 1'b1;
      repeat (2) @(negedge clk);
      mat_raw = 1'b0;
      repeat (20) @(negedge clk);
      check("bounce_pressure", int'(pressure), 0);
      check("bounce_count",    int'(entry_count), 1);

      // ---- Obstruction from the 5th HOLD cycle for 10 cycles ----------------
      // HOLD is entered at F0+6, so its 5th evaluating edge is F0+11; the last
      // reload is at F0+20 and the fall follows 8 edges later.
      step(8, 1'b0, f0);
      expect_ev(f0 + 28, EV_FALL, 0);
      wait_to(f0 + 10);
      obstruct = 1'b1;
      wait_to(f0 + 20);
      obstruct = 1'b0;
      wait_to(f0 + 32);

      // ---- Re-step while hcnt = 1 -------------------------------------------
      // Mat high first sampled at F0+8 -> filt rises at F0+13, the same edge
      // hcnt reaches 1, so the FSM sees both at F0+14 and returns to ACTIVE.
      step(8, 1'b0, f0);
      wait_to(f0 + 7);
      mat_raw = 1'b1;
      wait_to(f0 + 17);
      mat_raw = 1'b0;
      f1 = edge_n + 1;
      expect_ev(f1 + LAT_FALL, EV_FALL, 0);
      wait_to(f1 + LAT_FALL + 4);
      check("restep_count", int'(entry_count), 3);

      // ---- Asynchronous reset mid-HOLD --------------------------------------
      step(8, 1'b0, f0);
      wait_to(f0 + 9);
      expect_ev(f0 + 10, EV_FALL, 0);   // monitor sees the drop at its next sample
      #3 rst = 1'b1;
      #1;
      check("rst_hold_pressure", int'(pressure), 0);
      check("rst_hold_pulse",    int'(entry_pulse), 0);
      check("rst_hold_count",    int'(entry_count), 0);
      exp_count = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_pressure", int'(pressure), 0);

      // ---- Saturation: 256 clean entries ------------------------------------
      for (int i = 0; i < 256; i++) begin
         step(8, 1'b1, f0);
         wait_to(f0 + LAT_FALL + 2);
      end
      check("sat_count", int'(entry_count), 255);
      repeat (5) @(negedge clk);
      check("sat_count_stays", int'(entry_count), 255);

      // ---- Drain the scoreboard (bounded) -----------------------------------
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      while (exp_q.size() != 0) begin
         ev_t ev;
         ev = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: got nothing, required %s at edge %0d cnt %0d",
                  ev.kind.name(), ev.edge_no, ev.cnt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
